aes_cbc_unchain: RTL and testbench
==================================

Name: aes_cbc_unchain

Overview:
- Downstream stage of the combinational AES-128 Decryption core.
- Takes each raw decrypted block together with the ciphertext that produced it, and applies the CBC un-chaining step: plaintext = raw XOR previous ciphertext (the IV for the first block).
- Registers the result behind a valid/ready handshake, so the combinational decryptor gets a clean, flow-controlled output point toward the host or DMA interface.

Parameters:
- BLK_W, 128, block width in bits; fixed by AES.
- CNT_W, 32, width of the processed-block counter.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; returns the block to IDLE
- iv_load  input  1  load the chaining register from iv_in
- iv_in  input  BLK_W  initialisation vector
- in_valid  input  1  dec_in/ct_in are valid
- in_ready  output  1  stage accepts a block this cycle
- dec_in  input  BLK_W  raw output of the Decryption core (data_decrypted)
- ct_in  input  BLK_W  ciphertext that was fed to the Decryption core for this block
- out_valid  output  1  plaintext valid
- out_ready  input  1  downstream accepts plaintext
- out_data  output  BLK_W  recovered plaintext
- blk_cnt  output  CNT_W  blocks accepted since the last IV load

Behaviour:
- Reset (rst_n low, asynchronous) sets: state IDLE, out_valid 0, out_data 0, chain register 0, blk_cnt 0.
- States:
  - IDLE: no IV loaded; in_ready = 0.
  - RUN: chaining active.
- Transitions:
  - IDLE -> RUN on iv_load.
  - RUN -> RUN on iv_load (re-key of the chain): chain <= iv_in, blk_cnt <= 0.
  - any -> IDLE on clear.
- in_ready = (state == RUN) && !iv_load && !clear && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. On accept, next edge:
  - out_data <= dec_in ^ chain
  - chain <= ct_in
  - out_valid <= 1
  - blk_cnt <= blk_cnt + 1, wrapping modulo 2^CNT_W
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 block/cycle when out_ready is held high.
- Output handshake:
  - out_valid drops when out_ready && !accept.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- iv_load while out_valid is pending:
  - The pending output is unaffected and still drains normally.
  - The IV affects only subsequently accepted blocks.
- clear takes priority over iv_load and over accept. On clear, next edge:
  - out_valid <= 0; pending output is discarded.
  - chain <= 0, blk_cnt <= 0, state IDLE.
- in_valid in IDLE is ignored (in_ready = 0); no counter change.
- Upstream must hold dec_in/ct_in stable while in_valid && !in_ready.
- Reset mid-stream: all state is lost; the host must reload the IV.

Optional Feature:
- Macro: AES_CBC_ECB_BYPASS_EN.
- When defined:
  - Adds input port ecb_mode (1 bit), sampled per accept.
  - When ecb_mode = 1: out_data <= dec_in and the chain register is not updated.
  - RUN is entered without iv_load while ecb_mode = 1: in_ready ignores the IDLE state.
- When undefined: no ecb_mode port; behaviour is pure CBC as above.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W = 128
  - the state enum (IDLE, RUN)
  - the NIST SP800-38A CBC test-vector constants, shared with the benches
- One natural sub-module, aes_reg_slice: a BLK_W-wide single-stage valid/ready output register with hold-on-stall.
- aes_cbc_unchain instantiates aes_reg_slice and keeps the FSM, chain register and counter.

Test Plan:
- Reset, then in_valid = 1 without iv_load -> in_ready = 0; no output; blk_cnt = 0.
- IV load and first block:
  - Stimulus: iv_in = 000102030405060708090a0b0c0d0e0f with iv_load; then dec_in = 6bc0bce12a459991e134741a7f9e1925, ct_in = 7649abac8119b246cee98e9b12e9197d.
  - Response: one cycle later out_data = 6bc1bee22e409f96e93d7e117393172a, out_valid = 1, blk_cnt = 1.
- Second block:
  - Stimulus: dec_in = (ae2d8a571e03ac9c9eb76fac45af8e51 ^ 7649abac8119b246cee98e9b12e9197d), ct_in = 5086cb9b507219ee95db113a917678b2.
  - Response: out_data = ae2d8a571e03ac9c9eb76fac45af8e51, blk_cnt = 2.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles while in_valid = 1.
  - Response: in_ready = 0; out_data stable; no block lost or duplicated after release.
  - Then stream 4 blocks with out_ready = 1: 4 consecutive out_valid cycles.
- clear with out_valid pending and iv_load in the same cycle:
  - Response: out_valid = 0, state IDLE, blk_cnt = 0; the subsequent block is refused until a new iv_load.
- Async reset mid-stream (rst_n low between edges):
  - Response: out_valid goes to 0 immediately, not at the next edge.
  - After release, in_ready = 0 until iv_load.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, CBC stage states and the NIST SP800-38A
// AES-128 CBC example vectors used by the benches.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } cbc_state_e;

  localparam logic [AES_BLK_W-1:0] NIST_CBC_IV = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [AES_BLK_W-1:0] NIST_CBC_PT [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710
  };

  localparam logic [AES_BLK_W-1:0] NIST_CBC_CT [4] = '{
    128'h7649abac8119b246cee98e9b12e9197d,
    128'h5086cb9b507219ee95db113a917678b2,
    128'h73bed6b8e3c1743b7116e69e22229516,
    128'h3ff1caa1681fac09120eca307586e1a7
  };

  function automatic logic [AES_BLK_W-1:0] cbc_unchain(input logic [AES_BLK_W-1:0] raw,
                                                       input logic [AES_BLK_W-1:0] prev);
    return raw ^ prev;
  endfunction

endpackage

// File: rtl/aes_reg_slice.sv
// Single-stage valid/ready output register; holds data and valid while stalled.
module aes_reg_slice #(
  parameter int unsigned Width = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             push;

  assign ready_o = !valid_q || ready_i;
  assign push    = valid_i && ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/aes_cbc_unchain.sv
// CBC un-chaining stage behind the AES-128 decryptor: plaintext = raw ^ previous ciphertext.
// Optional AES_CBC_ECB_BYPASS_EN adds ecb_mode, which passes raw blocks through unchained.
module aes_cbc_unchain
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W = AES_BLK_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_CBC_ECB_BYPASS_EN
  input  logic             ecb_mode,
`endif
  input  logic             clear,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] dec_in,
  input  logic [BLK_W-1:0] ct_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic [CNT_W-1:0] blk_cnt
);

  cbc_state_e       state_q, state_d;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slice_ready;
  logic             accept;
  logic             ecb;
  logic [BLK_W-1:0] pt;

`ifdef AES_CBC_ECB_BYPASS_EN
  assign ecb = ecb_mode;
`else
  assign ecb = 1'b0;
`endif

  // ECB blocks need no IV, so they may be accepted straight out of IDLE.
  assign in_ready = ((state_q == StRun) || ecb) && !iv_load && !clear && slice_ready;
  assign accept   = in_valid && in_ready;
  assign pt       = ecb ? dec_in : cbc_unchain(dec_in, chain_q);

  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
      chain_d = '0;
      cnt_d   = '0;
    end else if (iv_load) begin
      state_d = StRun;
      chain_d = iv_in;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = StRun;
      cnt_d   = cnt_q + CNT_W'(1);
      if (!ecb) begin
        chain_d = ct_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      chain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
    end
  end

  aes_reg_slice #(
    .Width(BLK_W)
  ) u_out_slice (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(clear),
    .valid_i(accept),
    .data_i (pt),
    .ready_o(slice_ready),
    .valid_o(out_valid),
    .data_o (out_data),
    .ready_i(out_ready)
  );

  assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_aes_cbc_unchain.sv
// Self-checking bench for aes_cbc_unchain: transaction-level CBC model plus NIST vectors.
module tb_aes_cbc_unchain;
  import aes_pkg::*;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic             iv_load = 1'b0;
  logic [BLK_W-1:0] iv_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BLK_W-1:0] dec_in = '0;
  logic [BLK_W-1:0] ct_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [BLK_W-1:0] out_data;
  logic [CNT_W-1:0] blk_cnt;

  always #5 clk = ~clk;

  aes_cbc_unchain #(
    .BLK_W(BLK_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef AES_CBC_ECB_BYPASS_EN
    .ecb_mode (1'b0),
`endif
    .clear    (clear),
    .iv_load  (iv_load),
    .iv_in    (iv_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dec_in   (dec_in),
    .ct_in    (ct_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .blk_cnt  (blk_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act,
                     input logic [BLK_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an armed flag, the chaining value, a block count and a queue of
  // plaintexts owed downstream (at most one, since the stage has one slot).
  bit               m_run = 1'b0;
  logic [BLK_W-1:0] m_chain = '0;
  int unsigned      m_cnt = 0;
  logic [BLK_W-1:0] m_q[$];

  function automatic bit m_in_ready();
    return m_run && !iv_load && !clear && (m_q.size() == 0 || out_ready);
  endfunction

  always @(negedge rst_n) begin
    m_run   = 1'b0;
    m_chain = '0;
    m_cnt   = 0;
    m_q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = in_valid && m_in_ready();
      if (clear) begin
        m_run   = 1'b0;
        m_chain = '0;
        m_cnt   = 0;
        m_q.delete();
      end else begin
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (iv_load) begin
          m_run   = 1'b1;
          m_chain = iv_in;
          m_cnt   = 0;
        end else if (acc) begin
          m_q.push_back(dec_in ^ m_chain);
          m_chain = ct_in;
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", BLK_W'(in_ready), BLK_W'(m_in_ready()));
      chk("out_valid", BLK_W'(out_valid), BLK_W'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
      chk("blk_cnt", BLK_W'(blk_cnt), BLK_W'(m_cnt));
    end
  end

  function automatic logic [BLK_W-1:0] raw_blk(input int i);
    return NIST_CBC_PT[i] ^ ((i == 0) ? NIST_CBC_IV : NIST_CBC_CT[i-1]);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BLK_W-1:0] d, input logic [BLK_W-1:0] c);
    int t;
    in_valid = 1'b1;
    dec_in   = d;
    ct_in    = c;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", BLK_W'(in_ready), BLK_W'(1));
    next_cyc();
    in_valid = 1'b0;
  endtask

  int nv;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("rst_out_valid", BLK_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_blk_cnt", BLK_W'(blk_cnt), '0);
    next_cyc();
    rst_n = 1'b1;

    // IDLE refuses blocks
    in_valid = 1'b1;
    dec_in   = 128'h6bc0bce12a459991e134741a7f9e1925;
    ct_in    = 128'h7649abac8119b246cee98e9b12e9197d;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", BLK_W'(in_ready), '0);
      chk("idle_blk_cnt", BLK_W'(blk_cnt), '0);
      next_cyc();
    end

    // IV load, then NIST blocks 1 and 2
    iv_in   = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load = 1'b1;
    next_cyc();
    iv_load = 1'b0;
    @(negedge clk);
    chk("run_in_ready", BLK_W'(in_ready), BLK_W'(1));
    next_cyc();
    dec_in = 128'hae2d8a571e03ac9c9eb76fac45af8e51 ^ 128'h7649abac8119b246cee98e9b12e9197d;
    ct_in  = 128'h5086cb9b507219ee95db113a917678b2;
    @(negedge clk);
    chk("blk1_data", out_data, 128'h6bc1bee22e409f96e93d7e117393172a);
    chk("blk1_valid", BLK_W'(out_valid), BLK_W'(1));
    chk("blk1_cnt", BLK_W'(blk_cnt), BLK_W'(1));
    next_cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("blk2_data", out_data, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
    chk("blk2_cnt", BLK_W'(blk_cnt), BLK_W'(2));
    next_cyc();

    // Backpressure: block 3 stalls for 5 cycles while block 4 waits
    out_ready = 1'b0;
    send(raw_blk(2), NIST_CBC_CT[2]);
    in_valid = 1'b1;
    dec_in   = raw_blk(3);
    ct_in    = NIST_CBC_CT[3];
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", BLK_W'(in_ready), '0);
      chk("bp_hold_data", out_data, 128'h30c81c46a35ce411e5fbc1191a0a52ef);
      next_cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", BLK_W'(in_ready), BLK_W'(1));
    next_cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("blk4_data", out_data, 128'hf69f2445df4f9b17ad2b417be66c3710);
    chk("blk4_cnt", BLK_W'(blk_cnt), BLK_W'(4));
    next_cyc();

    // Re-key and stream 4 blocks back to back
    iv_in   = NIST_CBC_IV;
    iv_load = 1'b1;
    next_cyc();
    iv_load = 1'b0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      dec_in   = raw_blk(i);
      ct_in    = NIST_CBC_CT[i];
      @(negedge clk);
      nv += int'(out_valid);
      next_cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    nv += int'(out_valid);
    next_cyc();
    @(negedge clk);
    nv += int'(out_valid);
    chk("stream_valid_cycles", BLK_W'(nv), BLK_W'(4));
    next_cyc();

    // clear + iv_load together with an output pending
    out_ready = 1'b0;
    send(raw_blk(0), NIST_CBC_CT[0]);
    clear   = 1'b1;
    iv_load = 1'b1;
    next_cyc();
    clear    = 1'b0;
    iv_load  = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("clr_out_valid", BLK_W'(out_valid), '0);
      chk("clr_blk_cnt", BLK_W'(blk_cnt), '0);
      chk("clr_in_ready", BLK_W'(in_ready), '0);
      next_cyc();
    end
    out_ready = 1'b1;
    iv_load   = 1'b1;
    next_cyc();
    iv_load = 1'b0;
    next_cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_reload_data", out_data, 128'h6bc1bee22e409f96e93d7e117393172a);
    chk("clr_reload_cnt", BLK_W'(blk_cnt), BLK_W'(1));
    next_cyc();

    // Async reset between edges with an output pending
    out_ready = 1'b0;
    send(raw_blk(1), NIST_CBC_CT[1]);
    @(negedge clk);
    chk("pre_rst_valid", BLK_W'(out_valid), BLK_W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", BLK_W'(out_valid), '0);
    chk("async_rst_cnt", BLK_W'(blk_cnt), '0);
    #1 rst_n = 1'b1;
    next_cyc();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_in_ready", BLK_W'(in_ready), '0);
      next_cyc();
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
